// File: rtl/ofdm_pkg.sv
// Shared types and constellation constants for the OFDM transmit chain.
// Levels are Q2.10 magnitudes; the sign is applied by the consumer.
package ofdm_pkg;

    localparam int BLK_SIZE_DEFAULT = 1152;
    localparam int IQ_W_DEFAULT     = 12;

    typedef enum logic [1:0] {
        BPSK  = 2'd0,
        QPSK  = 2'd1,
        QAM16 = 2'd2,
        QAM64 = 2'd3
    } mod_t;

    localparam logic [10:0] LVL_BPSK = 11'd1024;
    localparam logic [10:0] LVL_QPSK = 11'd724;
    localparam logic [10:0] LVL16_O  = 11'd972;
    localparam logic [10:0] LVL16_I  = 11'd324;
    localparam logic [10:0] LVL64_7  = 11'd1106;
    localparam logic [10:0] LVL64_5  = 11'd790;
    localparam logic [10:0] LVL64_3  = 11'd474;
    localparam logic [10:0] LVL64_1  = 11'd158;

    // Coded bits per subcarrier.
    function automatic logic [2:0] ncpc(input mod_t m);
        case (m)
            BPSK:    return 3'd1;
            QPSK:    return 3'd2;
            QAM16:   return 3'd4;
            default: return 3'd6;
        endcase
    endfunction

    // Gray-coded 64-QAM magnitude; code is {first bit, second bit}.
    function automatic logic [10:0] lvl64(input logic [1:0] code);
        case (code)
            2'b00:   return LVL64_7;
            2'b01:   return LVL64_5;
            2'b11:   return LVL64_3;
            default: return LVL64_1;
        endcase
    endfunction

endpackage

// File: rtl/qam_level_lut.sv
// Combinational Gray-mapped constellation lookup: modulation + 6 bits -> I/Q.
// Shared with the preamble and pilot generators.
module qam_level_lut
    import ofdm_pkg::*;
#(
    parameter int IQ_W = IQ_W_DEFAULT
) (
    input  logic                   [1:0]      mod,
    input  logic                   [5:0]      bits,
    output logic signed            [IQ_W-1:0] i,
    output logic signed            [IQ_W-1:0] q
);

    logic [10:0]     mag_i, mag_q;
    logic            neg_i, neg_q;
    logic [IQ_W-1:0] ext_i, ext_q;

    // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned (which would infer a latch).
    always_comb begin
        mag_i = '0;
        mag_q = '0;
        neg_i = 1'b0;
        neg_q = 1'b0;
        case (mod_t'(mod))
            BPSK: begin
                mag_i = LVL_BPSK;
                neg_i = bits[0];
            end
            QPSK: begin
                mag_i = LVL_QPSK;
                neg_i = bits[0];
                mag_q = LVL_QPSK;
                neg_q = bits[1];
            end
            QAM16: begin
                mag_i = bits[1] ? LVL16_I : LVL16_O;
                neg_i = bits[0];
                mag_q = bits[3] ? LVL16_I : LVL16_O;
                neg_q = bits[2];
            end
            default: begin
                mag_i = lvl64({bits[1], bits[2]});
                neg_i = bits[0];
                mag_q = lvl64({bits[4], bits[5]});
                neg_q = bits[3];
            end
        endcase
    end

    assign ext_i = IQ_W'(mag_i);
    assign ext_q = IQ_W'(mag_q);
    assign i     = neg_i ? -ext_i : ext_i;
    assign q     = neg_q ? -ext_q : ext_q;

endmodule

// File: rtl/ofdm_qam_mapper.sv
// Constellation mapper: takes one interleaved block per handshake and
// streams one I/Q subcarrier per cycle, decoding the low bits of a shift register.
module ofdm_qam_mapper
    import ofdm_pkg::*;
#(
    parameter int BLK_SIZE = BLK_SIZE_DEFAULT,
    parameter int IQ_W     = IQ_W_DEFAULT
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic        [BLK_SIZE-1:0] in_blk,
    input  logic                       in_blk_valid,
    output logic                       in_blk_ready,
    input  logic        [1:0]          mod_id,
    input  logic        [7:0]          n_sc,
    output logic signed [IQ_W-1:0]     out_i,
    output logic signed [IQ_W-1:0]     out_q,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic                       out_last
);

    typedef enum logic {
        S_IDLE,
        S_EMIT
    } state_t;

    state_t                state;
    logic [7:0]            count;
    logic [BLK_SIZE-1:0]   sreg;
    mod_t                  mod_r;
    logic                  ready_r;
    logic signed [IQ_W-1:0] lut_i, lut_q;

    // NOTE: the shift register is a plain datapath register, not a RAM, so clearing it on reset is cheap and keeps aborted data from resurfacing.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= S_IDLE;
            count   <= '0;
            sreg    <= '0;
            mod_r   <= BPSK;
            ready_r <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of statement order.
            case (state)
                S_IDLE: begin
                    ready_r <= 1'b1;
                    if (ready_r && in_blk_valid) begin
                        sreg  <= in_blk;
                        mod_r <= mod_t'(mod_id);
                        if (n_sc != '0) begin
                            state   <= S_EMIT;
                            count   <= n_sc - 8'd1;
                            ready_r <= 1'b0;
                        end
                    end
                end
                S_EMIT: begin
                    if (out_ready) begin
                        if (count == '0) begin
                            state   <= S_IDLE;
                            ready_r <= 1'b1;
                        end else begin
                            count <= count - 8'd1;
                            // Zero fill means an overrun block simply emits zero-bit symbols.
                            sreg  <= sreg >> ncpc(mod_r);
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    qam_level_lut #(
        .IQ_W (IQ_W)
    ) u_lut (
        .mod  (mod_r),
        .bits (sreg[5:0]),
        .i    (lut_i),
        .q    (lut_q)
    );

    assign in_blk_ready = ready_r;
    assign out_valid    = (state == S_EMIT);
    assign out_last     = out_valid && (count == '0);
    assign out_i        = out_valid ? lut_i : '0;
    assign out_q        = out_valid ? lut_q : '0;

endmodule

// File: doc/ofdm_qam_mapper.md
# ofdm_qam_mapper

Constellation mapper downstream of the block interleaver in the WiMAX OFDM transmit chain. It accepts one interleaved coded block (Ncbps bits, parallel) per handshake and emits one complex I/Q subcarrier value per cycle to the IFFT/subcarrier-allocation stage. It supports BPSK, QPSK, 16-QAM and 64-QAM with Gray mapping and fixed-point normalisation.

## Interface
- `BLK_SIZE`, 1152: input block width in bits; the maximum Ncbps (64-QAM, 16 subchannels).
- `IQ_W`, 12: signed I/Q output width, Q2.10 format (1.0 = 1024).
- `clk` in 1: single clock; all logic on posedge.
- `reset` in 1: reset, synchronous, active-low.
- `in_blk` in BLK_SIZE: interleaved block; bit 0 is the first coded bit.
- `in_blk_valid` in 1: block present.
- `in_blk_ready` out 1: mapper can accept a block.
- `mod_id` in 2: 0 BPSK, 1 QPSK, 2 16-QAM, 3 64-QAM; sampled on accept.
- `n_sc` in 8: number of subcarriers in the block (valid 1..192); sampled on accept.
- `out_i`, `out_q` out IQ_W: signed constellation point.
- `out_valid` out 1: symbol present.
- `out_ready` in 1: downstream accepts the symbol.
- `out_last` out 1: current symbol is the last of its block.

## Operation
- Ncpc = 1/2/4/6 for mod_id 0/1/2/3. Subcarrier s uses bits [s·Ncpc +: Ncpc] of the block, in order b0..b(Ncpc-1).
- The block is held in a shift register that shifts right by Ncpc on each output transfer. The current symbol is always decoded from the low 6 bits.
- Mapping rules:
  - Sign bit 0 gives a positive value, 1 gives a negative value.
  - BPSK: b0 is the I sign, I = ±1024, Q = 0.
  - QPSK: b0 is the I sign, b1 is the Q sign, magnitude 724.
  - 16-QAM: I uses b0 as sign and b1 as magnitude (0 → 972, 1 → 324). Q uses b2 and b3 the same way.
  - 64-QAM: I uses b0 as sign and b1b2 as magnitude code (00 → 1106, 01 → 790, 11 → 474, 10 → 158). Q uses b3 as sign and b4b5 as magnitude code.
- All levels are constants; the block contains no multipliers.
- FSM states:
  - IDLE: `in_blk_ready` = 1. On `in_blk_valid`, the block loads. If n_sc = 0 the block is dropped and the FSM stays in IDLE. Otherwise the FSM goes to EMIT with remaining count = n_sc-1.
  - EMIT: `out_valid` = 1. On `out_valid & out_ready`: if count = 0, the FSM returns to IDLE. Otherwise count decrements and the register shifts.
- `out_last` = (state == EMIT) & (count == 0).
- `out_i` and `out_q` are forced to 0 whenever `out_valid` = 0.
- `in_blk_valid` during EMIT is ignored; the upstream stage holds the block.
- n_sc·Ncpc > BLK_SIZE is a caller error. In that case the mapper emits zero-filled bits for the overrun subcarriers and performs no other checking.

## Timing
- Reset (`reset` = 0 at a posedge): state IDLE, count 0, shift register 0. `out_valid`, `out_last`, `out_i` and `out_q` are all 0. `in_blk_ready` is 0 while `reset` = 0 and 1 from the first cycle after release.
- Reset mid-block aborts the block: `out_valid` is 0 the cycle after the reset edge, and no further symbols from that block appear.
- Latency: the first symbol is valid the cycle after the accept edge.
- Throughput: one symbol per cycle under `out_ready` = 1, giving n_sc + 1 cycles per block (one IDLE accept cycle between blocks).
- Backpressure: while `out_valid & !out_ready`, `out_i`, `out_q` and `out_last` hold stable and no state changes.
- `in_blk_ready` is registered state, with no combinational path from `out_ready`.
- `out_i`, `out_q` and `out_last` are combinational decodes of registered state only.

## Structure
- Package `ofdm_pkg`:
  - `mod_t` enum (BPSK, QPSK, QAM16, QAM64).
  - `ncpc()` function.
  - Level constants: LVL_BPSK = 1024, LVL_QPSK = 724, LVL16_{O,I} = 972/324, LVL64_{7,5,3,1} = 1106/790/474/158.
  - `IQ_W` default.
- Sub-module `qam_level_lut`: combinational, takes mod_id plus 6 bits and returns I and Q. It is shared with the preamble and pilot generators.
- Top level contains the FSM, the count, and the shift register.

## Test plan
- **Reset:** hold `reset` = 0 for 3 cycles with `in_blk_valid` = 1 → `in_blk_ready` = 0, `out_valid` = 0, `out_i` = `out_q` = 0. After release, `in_blk_ready` = 1 on the next cycle.
- **BPSK:** n_sc = 4, in_blk[3:0] = 4'b1010, `out_ready` = 1 → I = +1024, -1024, +1024, -1024 on consecutive cycles, Q = 0, `out_last` on the 4th symbol only, `in_blk_ready` = 1 the following cycle.
- **16-QAM:** n_sc = 1, b0..b3 = 1,1,0,0 → I = -324, Q = +972, `out_last` = 1.
- **64-QAM:** n_sc = 1, b0..b5 = 0,0,0,1,1,0 → I = +1106, Q = -158.
- **QPSK backpressure:** n_sc = 3, bits 01 10 11, `out_ready` low for 5 cycles on symbol 2 → symbol 2 (I = +724, Q = -724) held stable for all 5 cycles. Exactly 3 symbols delivered in total: (-724,+724), (+724,-724), (-724,-724).
- **Overlap, drop and abort:**
  - `in_blk_valid` pulsed during EMIT → ignored, with the symbol count unchanged.
  - n_sc = 0 block → no output, and `in_blk_ready` = 1 the next cycle.
  - `reset` low at symbol 5 of 192 → `out_valid` = 0 the next cycle.
